// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the memory-access stage
package mem_stage_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane replication/strobes and load extract/extension
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic        sext,
    input  logic [31:0] wdata_raw,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Byte/half data is replicated across all lanes; strobes pick the live lane.
    always_comb begin
        wstrb     = 4'b1111;
        wdata     = wdata_raw;
        shifted   = rdata >> {addr_lo, 3'b000};
        load_data = shifted;
        case (size)
            MEM_SIZE_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata     = {4{wdata_raw[7:0]}};
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            MEM_SIZE_H: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{wdata_raw[15:0]}};
                load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata     = wdata_raw;
                load_data = shifted;
            end
        endcase
        if (!is_store) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with data-SRAM handshake
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_to_mem_valid,
    output logic        o_mem_ready,
    output logic        mem_to_wb_valid,
    input  logic        i_wb_ready,
    output logic        mem_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_alu_result,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_sext,
    input  logic [31:0] ex_mem_wdata,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_inst,
    output logic        mem_rf_we,
    output logic [4:0]  mem_rf_waddr,
    output logic [31:0] mem_rf_wdata
);

    mem_state_e  state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, alu_result_q, alu_result_d;
    logic        rf_we_q, rf_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_sext_q, mem_sext_d;
    logic [31:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
    logic        is_mem, ready_go, latch, handoff;
    logic [31:0] load_data;

    assign is_mem          = mem_re_q | mem_we_q;
    assign ready_go        = ~is_mem | (state_q == ST_DONE);
    assign o_mem_ready     = ~valid_q | (ready_go & i_wb_ready);
    assign mem_to_wb_valid = valid_q & ready_go;
    assign mem_valid       = valid_q;
    assign latch           = ex_to_mem_valid & o_mem_ready;
    assign handoff         = mem_to_wb_valid & i_wb_ready;

    assign data_sram_req   = valid_q & (state_q == ST_REQ);
    assign data_sram_wr    = mem_we_q;
    assign data_sram_size  = mem_size_q;
    assign data_sram_addr  = alu_result_q;
    assign mem_pc          = pc_q;
    assign mem_inst        = inst_q;
    assign mem_rf_we       = rf_we_q & valid_q;
    assign mem_rf_waddr    = rf_waddr_q;
    assign mem_rf_wdata    = mem_re_q ? load_data : alu_result_q;

    mem_align u_align (
        .size      (mem_size_q),
        .addr_lo   (alu_result_q[1:0]),
        .is_store  (mem_we_q),
        .sext      (mem_sext_q),
        .wdata_raw (mem_wdata_q),
        .rdata     (rdata_q),
        .wstrb     (data_sram_wstrb),
        .wdata     (data_sram_wdata),
        .load_data (load_data)
    );

    // Next-state: a new latch always restarts the FSM; otherwise walk the bus handshake.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        alu_result_d = alu_result_q;
        rf_we_d      = rf_we_q;
        rf_waddr_d   = rf_waddr_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        mem_size_d   = mem_size_q;
        mem_sext_d   = mem_sext_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        if (o_mem_ready) begin
            valid_d = ex_to_mem_valid;
        end
        if (latch) begin
            pc_d         = ex_pc;
            inst_d       = ex_inst;
            alu_result_d = ex_alu_result;
            rf_we_d      = ex_rf_we;
            rf_waddr_d   = ex_rf_waddr;
            mem_re_d     = ex_mem_re;
            mem_we_d     = ex_mem_we;
            mem_size_d   = ex_mem_size;
            mem_sext_d   = ex_mem_sext;
            mem_wdata_d  = ex_mem_wdata;
            state_d      = (ex_mem_re | ex_mem_we) ? ST_REQ : ST_IDLE;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (valid_q && data_sram_addr_ok) begin
                        if (data_sram_data_ok) begin
                            state_d = ST_DONE;
                            rdata_d = data_sram_rdata;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_sram_data_ok) begin
                        state_d = ST_DONE;
                        rdata_d = data_sram_rdata;
                    end
                end
                ST_DONE: begin
                    if (handoff) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            pc_q         <= '0;
            inst_q       <= '0;
            alu_result_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_size_q   <= '0;
            mem_sext_q   <= 1'b0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            alu_result_q <= alu_result_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_size_q   <= mem_size_d;
            mem_sext_q   <= mem_sext_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule
